cabac_bit_writer: RTL
=====================

Name: cabac_bit_writer

Overview:
- Output stage of the CABAC arithmetic encoder; it writes the bitstream that the decoder's bitsNeeded/byte-request path consumes.
- Owns the encoder `low` register and the `bitsLeft` counter, and applies each renormalisation op (shift + add) produced by the bin coder.
- Emits bytes with carry propagation through outstanding 0xFF bytes.
- Handles end-of-slice flush, including the final partial byte.

Parameters:
- LOW_W, 32, width of low register.
- BITS_LEFT_INIT, 23, bitsLeft value after reset and after each flush.
- CNT_W, 16, width of outstanding-byte counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  op valid
- in_ready  out  1  op accepted when in_valid & in_ready
- in_shift  in  4  left-shift amount, 0..8 (LPS numBits, MPS renorm 1, bypass nBins)
- in_add  in  LOW_W  value added after shift (already aligned by bin coder)
- in_flush  in  1  op is end-of-slice flush; in_shift/in_add ignored
- out_valid  out  1  byte beat valid
- out_ready  in  1  downstream accepts beat
- out_data  out  8  byte; partial final beat is MSB-aligned, unused LSBs 0
- out_nbits  out  4  valid bits in beat, 8 except final partial beat (1..7)
- out_last  out  1  last beat of a flush
- cnt_ovf  out  1  sticky: outstanding counter would exceed 2^CNT_W-1

Behaviour:
- Reset (async, rst_n=0):
  - low=0, bitsLeft=BITS_LEFT_INIT, count=0, buffered=0, state IDLE.
  - out_valid=0, out_data=0, out_nbits=0, out_last=0, cnt_ovf=0.
  - in_ready=1 after release.
- in_ready=1 only in IDLE.
- Out handshake:
  - A beat transfers when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_data, out_nbits and out_last hold stable.
- Normal op accepted in IDLE, evaluated in the accept cycle with 9-bit lead, then registered:
  - low' = (low<<in_shift)+in_add; bL = bitsLeft-in_shift.
  - If bL>=12: commit low', bitsLeft=bL; stay IDLE.
  - Else: lead = low'>>(24-bL); bitsLeft=bL+8; low = low' & (all-ones>>(bL+8)). Then:
    - lead==0xFF: count+1, stay IDLE; at saturation hold count and set cnt_ovf.
    - count==0: buffered=lead[7:0], count=1, stay IDLE.
    - else: carry=lead[8]; enter EMIT_BUF.
- EMIT_BUF: beat = buffered+carry (8-bit wrap). On transfer:
  - count>1: go to EMIT_RUN.
  - else: buffered=lead[7:0], count=1, go to IDLE.
- EMIT_RUN: beat = carry?0x00:0xFF, repeated count-1 times, one beat per transfer. Then buffered=lead[7:0], count=1, go to IDLE.
- in_shift=8 with bitsLeft=12 yields bL=4, so at most one lead byte per op.
- Flush, accepted in IDLE:
  - fc = low>>(32-bitsLeft) nonzero.
  - If fc: emit buffered+1, then count-1 beats of 0x00; low -= 1<<(32-bitsLeft).
  - Else if count>0: emit buffered, then count-1 beats of 0xFF.
  - Then tail: n = 24-bitsLeft bits of low>>8, MSB first, as full bytes (nbits 8) plus one partial beat if n mod 8 ≠ 0.
  - out_last is set on the final tail beat. If n=0, out_last goes on the final buffered/run beat. If nothing at all is emitted, a single beat with nbits=0 and last=1 is sent.
  - After the last transfer, restore reset values of low, bitsLeft and count (cnt_ovf kept) and return to IDLE.
- States: IDLE, EMIT_BUF, EMIT_RUN, FLUSH_BUF, FLUSH_RUN, FLUSH_TAIL.
- Throughput: one op/cycle when no byte emitted; one beat/cycle when out_ready=1.
- Reset mid-burst: all pending beats discarded; out_valid drops asynchronously.

Test Plan:
- Reset, ops (shift8, add0), (shift8, add0x240000):
  - No out beat; in_ready stays 1.
  - buffered=0x12, count=1, bitsLeft=15, low=0.
- Continue with (shift8, add0x340000):
  - One beat 0x12, nbits 8.
  - buffered=0x1A, bitsLeft=15.
- Carry run: buffered 0x12, two ops add 0x1FE0000 (lead 0xFF each, count 3), then add 0x20A0000 (lead 0x105):
  - Beats 0x13, 0x00, 0x00.
  - buffered=0x05, count=1.
- No-carry run: same as above but final lead 0x005 (add 0x0A0000):
  - Beats 0x12, 0xFF, 0xFF.
- Backpressure: hold out_ready=0 for 5 cycles mid-run:
  - out_data stable, in_ready=0, no beats lost or duplicated.
- Flush with buffered 0x1A, count 1, low 0, bitsLeft 15:
  - Beats 0x1A/8, 0x00/8, 0x00/1 with last=1.
  - Then in_ready=1, bitsLeft=23.
- Assert rst_n=0 during EMIT_RUN:
  - out_valid=0 immediately, state IDLE, count=0 after release.

Source files
------------

// File: rtl/cabac_bit_writer.sv
`default_nettype none
// ============================================================================
// cabac_bit_writer : CABAC encoder low/bitsLeft register, byte output with
//                    carry propagation through 0xFF runs, end-of-slice flush.
// Revision 1.0
// ============================================================================
module cabac_bit_writer #(
  parameter int LOW_W          = 32,
  parameter int BITS_LEFT_INIT = 23,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_shift,
  input  logic [LOW_W-1:0] in_add,
  input  logic             in_flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [3:0]       out_nbits,
  output logic             out_last,
  output logic             cnt_ovf
);

  localparam int              BL_W      = 6;
  localparam logic [BL_W-1:0] C_LOW_W   = BL_W'(LOW_W);
  localparam logic [BL_W-1:0] C_BL_INIT = BL_W'(BITS_LEFT_INIT);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    EMIT_BUF   = 3'd1,
    EMIT_RUN   = 3'd2,
    FLUSH_BUF  = 3'd3,
    FLUSH_RUN  = 3'd4,
    FLUSH_TAIL = 3'd5
  } state_t;

  state_t           state;
  logic [LOW_W-1:0] low;
  logic [BL_W-1:0]  bits_left;
  logic [CNT_W-1:0] count;
  logic [7:0]       buffered;
  logic [7:0]       pend;
  logic [7:0]       run_byte;
  logic [LOW_W-1:0] tail_sr;
  logic [BL_W-1:0]  tail_rem;

  logic [LOW_W-1:0] low_sh;
  logic [LOW_W-1:0] low_mask;
  logic [LOW_W-1:0] low_fl;
  logic [LOW_W-1:0] tail_init;
  logic [BL_W-1:0]  bl_new;
  logic [BL_W-1:0]  fl_sh;
  logic [BL_W-1:0]  tail_n;
  logic [8:0]       lead;
  logic             fc;

  assign in_ready = (state == IDLE);

  function automatic logic [3:0] nbits_of(input logic [BL_W-1:0] r);
    return (r >= 6'd8) ? 4'd8 : r[3:0];
  endfunction

  function automatic logic [BL_W-1:0] rem_after(input logic [BL_W-1:0] r);
    return (r > 6'd8) ? (r - 6'd8) : '0;
  endfunction

  always_comb begin
    low_sh    = (low << in_shift) + in_add;
    bl_new    = bits_left - BL_W'(in_shift);
    lead      = 9'(low_sh >> (6'd24 - bl_new));
    low_mask  = {LOW_W{1'b1}} >> (bl_new + 6'd8);
    fl_sh     = C_LOW_W - bits_left;
    fc        = (low >> fl_sh) != '0;
    low_fl    = fc ? (low - (LOW_W'(1) << fl_sh)) : low;
    tail_n    = 6'd24 - bits_left;
    // Tail bits left-aligned so each beat is simply the top byte.
    tail_init = (low_fl >> 8) << (C_LOW_W - tail_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      low       <= '0;
      bits_left <= C_BL_INIT;
      count     <= '0;
      buffered  <= '0;
      pend      <= '0;
      run_byte  <= '0;
      tail_sr   <= '0;
      tail_rem  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_nbits <= '0;
      out_last  <= 1'b0;
      cnt_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_flush) begin
              run_byte <= fc ? 8'h00 : 8'hFF;
              tail_sr  <= tail_init;
              tail_rem <= tail_n;
              if (fc || count != '0) begin
                out_valid <= 1'b1;
                out_data  <= buffered + {7'd0, fc};
                out_nbits <= 4'd8;
                out_last  <= (count <= CNT_W'(1)) && (tail_n == '0);
                state     <= FLUSH_BUF;
              end else begin
                // Also covers the empty flush: nbits 0, last 1.
                out_valid <= 1'b1;
                out_data  <= tail_init[LOW_W-1 -: 8];
                out_nbits <= nbits_of(tail_n);
                out_last  <= (tail_n <= 6'd8);
                tail_sr   <= tail_init << 8;
                tail_rem  <= rem_after(tail_n);
                state     <= FLUSH_TAIL;
              end
            end else if (bl_new >= 6'd12) begin
              low       <= low_sh;
              bits_left <= bl_new;
            end else begin
              low       <= low_sh & low_mask;
              bits_left <= bl_new + 6'd8;
              if (lead == 9'h0FF) begin
                if (count == C_CNT_MAX) cnt_ovf <= 1'b1;
                else                    count   <= count + CNT_W'(1);
              end else if (count == '0) begin
                buffered <= lead[7:0];
                count    <= CNT_W'(1);
              end else begin
                pend      <= lead[7:0];
                run_byte  <= lead[8] ? 8'h00 : 8'hFF;
                out_valid <= 1'b1;
                out_data  <= buffered + {7'd0, lead[8]};
                out_nbits <= 4'd8;
                out_last  <= 1'b0;
                state     <= EMIT_BUF;
              end
            end
          end
        end

        // count doubles as the number of run beats still owed (incl. current).
        EMIT_BUF, EMIT_RUN: begin
          if (out_ready) begin
            if (count > CNT_W'(1)) begin
              count    <= count - CNT_W'(1);
              out_data <= run_byte;
              state    <= EMIT_RUN;
            end else begin
              buffered  <= pend;
              count     <= CNT_W'(1);
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end

        FLUSH_BUF, FLUSH_RUN: begin
          if (out_ready) begin
            if (count > CNT_W'(1)) begin
              count    <= count - CNT_W'(1);
              out_data <= run_byte;
              out_last <= (count == CNT_W'(2)) && (tail_rem == '0);
              state    <= FLUSH_RUN;
            end else if (tail_rem != '0) begin
              out_data  <= tail_sr[LOW_W-1 -: 8];
              out_nbits <= nbits_of(tail_rem);
              out_last  <= (tail_rem <= 6'd8);
              tail_sr   <= tail_sr << 8;
              tail_rem  <= rem_after(tail_rem);
              state     <= FLUSH_TAIL;
            end else begin
              low       <= '0;
              bits_left <= C_BL_INIT;
              count     <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
            end
          end
        end

        FLUSH_TAIL: begin
          if (out_ready) begin
            if (out_last) begin
              low       <= '0;
              bits_left <= C_BL_INIT;
              count     <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
            end else begin
              out_data  <= tail_sr[LOW_W-1 -: 8];
              out_nbits <= nbits_of(tail_rem);
              out_last  <= (tail_rem <= 6'd8);
              tail_sr   <= tail_sr << 8;
              tail_rem  <= rem_after(tail_rem);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
